// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - round-robin scheduler sharing one ALU between two requesters
module alu_rr_sched #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_mode,
    input  logic         req0_chain,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_mode,
    input  logic         req1_chain,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic         alu_cb_in,
    output logic [2:0]   alu_mode,
    input  logic [N-1:0] alu_res,
    input  logic         alu_cb_out,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [N-1:0] rsp_res,
    output logic         rsp_cb,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [1:0]   carry_q, carry_d;
    logic         sel_q, sel_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [2:0]   mode_q, mode_d;
    logic         cb_in_q, cb_in_d;
    logic [N-1:0] rsp_res_q, rsp_res_d;
    logic         rsp_cb_q, rsp_cb_d;
    logic [1:0]   rsp_valid_q, rsp_valid_d;

    logic         grant0, grant1;
    logic [2:0]   in_mode;
    logic         in_chain;
    logic         arith;

    // On contention the port that did not win last time is chosen.
    assign grant0 = req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = req1_valid && !grant0;

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;

    assign in_mode  = grant1 ? req1_mode  : req0_mode;
    assign in_chain = grant1 ? req1_chain : req0_chain;
    assign arith    = (mode_q[2:1] == 2'b00);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        carry_d      = carry_q;
        sel_d        = sel_q;
        a_d          = a_q;
        b_d          = b_q;
        mode_d       = mode_q;
        cb_in_d      = cb_in_q;
        rsp_res_d    = rsp_res_q;
        rsp_cb_d     = rsp_cb_q;
        rsp_valid_d  = 2'b00;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    sel_d        = grant1;
                    a_d          = grant1 ? req1_a : req0_a;
                    b_d          = grant1 ? req1_b : req0_b;
                    mode_d       = in_mode;
                    cb_in_d      = (in_mode == 3'b000 && in_chain) ? carry_q[grant1] : 1'b0;
                    last_grant_d = grant1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_res_d          = alu_res;
                rsp_cb_d           = arith ? alu_cb_out : 1'b0;
                if (arith) begin
                    carry_d[sel_q] = alu_cb_out;
                end
                rsp_valid_d[sel_q] = 1'b1;
                state_d            = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            carry_q      <= 2'b00;
            sel_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            mode_q       <= 3'b000;
            cb_in_q      <= 1'b0;
            rsp_res_q    <= '0;
            rsp_cb_q     <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            carry_q      <= carry_d;
            sel_q        <= sel_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mode_q       <= mode_d;
            cb_in_q      <= cb_in_d;
            rsp_res_q    <= rsp_res_d;
            rsp_cb_q     <= rsp_cb_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_cb_in  = cb_in_q;
    assign alu_mode   = mode_q;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp_res    = rsp_res_q;
    assign rsp_cb     = rsp_cb_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_alu_rr_sched.sv
// tb/tb_alu_rr_sched.sv - self-checking bench for alu_rr_sched with a behavioural ALU
module tb_alu_rr_sched;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_chain;
    logic [N-1:0] req0_a, req0_b;
    logic [2:0]   req0_mode;
    logic         req1_valid, req1_ready, req1_chain;
    logic [N-1:0] req1_a, req1_b;
    logic [2:0]   req1_mode;
    logic [N-1:0] alu_a, alu_b, alu_res, rsp_res;
    logic         alu_cb_in, alu_cb_out, rsp0_valid, rsp1_valid, rsp_cb, busy;
    logic [2:0]   alu_mode;

    int checks = 0;
    int errors = 0;
    int mcarry[2];

    always #5 clk = ~clk;

    alu_rr_sched #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_mode(req0_mode), .req0_chain(req0_chain),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_mode(req1_mode), .req1_chain(req1_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cb_in(alu_cb_in), .alu_mode(alu_mode),
        .alu_res(alu_res), .alu_cb_out(alu_cb_out),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_res(rsp_res), .rsp_cb(rsp_cb),
        .busy(busy)
    );

    // Attached ALU; logic modes report parity on CB_out so a leaked flag is visible.
    logic [N:0] alu_tmp;
    always_comb begin
        alu_tmp = '0;
        case (alu_mode)
            3'd0: alu_tmp = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cb_in};
            3'd1: alu_tmp = {1'b0, alu_a} + {4'b0, alu_cb_in} - {1'b0, alu_b};
            3'd2: alu_tmp = {1'b0, alu_a & alu_b};
            3'd3: alu_tmp = {1'b0, alu_a | alu_b};
            3'd4: alu_tmp = {1'b0, alu_a ^ alu_b};
            3'd5: alu_tmp = {1'b0, ~alu_a};
            3'd6: alu_tmp = {1'b0, alu_a} + 5'd1;
            default: alu_tmp = {1'b0, alu_a} - 5'd1;
        endcase
        alu_res    = alu_tmp[N-1:0];
        alu_cb_out = (alu_mode >= 3'd2 && alu_mode <= 3'd5) ? ^alu_tmp[N-1:0] : alu_tmp[N];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on the requester-visible behaviour.
    task automatic model(input int port, input int a, input int b, input int mode, input int chain,
                         output int res, output int cb);
        int cin, s;
        cin = (mode == 0 && chain != 0) ? mcarry[port] : 0;
        cb  = 0;
        case (mode)
            0: begin s = a + b + cin; res = s % 16; cb = (s > 15) ? 1 : 0; end
            1: begin res = (a - b + 16) % 16; cb = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 15 - a;
            6: res = (a + 1) % 16;
            default: res = (a + 15) % 16;
        endcase
        if (mode <= 1) mcarry[port] = cb;
    endtask

    task automatic set_req(input int port, input logic v, input int a, input int b,
                           input int mode, input int chain);
        if (port == 0) begin
            req0_valid = v; req0_a = a[N-1:0]; req0_b = b[N-1:0];
            req0_mode = mode[2:0]; req0_chain = chain[0];
        end else begin
            req1_valid = v; req1_a = a[N-1:0]; req1_b = b[N-1:0];
            req1_mode = mode[2:0]; req1_chain = chain[0];
        end
    endtask

    task automatic do_op(input int port, input int a, input int b, input int mode, input int chain,
                         input int exp_res, input int exp_cb);
        int cnt;
        @(negedge clk);
        set_req(port, 1'b1, a, b, mode, chain);
        #1;
        cnt = 0;
        while (!(port == 0 ? req0_ready : req1_ready) && cnt < 10) begin
            @(negedge clk); #1; cnt++;
        end
        chk("ready_wait", cnt, 0);
        chk("other_ready", int'(port == 0 ? req1_ready : req0_ready), 0);
        @(posedge clk); #1;
        set_req(port, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        chk("exec_busy", int'(busy), 1);
        chk("exec_alu_a", int'(alu_a), a);
        chk("exec_alu_mode", int'(alu_mode), mode);
        chk("exec_no_rsp", int'({rsp1_valid, rsp0_valid}), 0);
        @(negedge clk);
        chk("rsp_valid", int'({rsp1_valid, rsp0_valid}), port == 0 ? 1 : 2);
        chk("rsp_res", int'(rsp_res), exp_res);
        chk("rsp_cb", int'(rsp_cb), exp_cb);
        @(negedge clk);
        chk("post_rsp", int'({busy, rsp1_valid, rsp0_valid}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mcarry[0] = 0; mcarry[1] = 0;
    endtask

    typedef struct {
        int port; int a; int b; int mode; int chain; int res; int cb;
    } vec_t;
    vec_t tbl[13];

    initial begin
        int r, c, cnt, exp_port;
        rst = 1'b1;
        set_req(0, 1'b0, 0, 0, 0, 0);
        set_req(1, 1'b0, 0, 0, 0, 0);
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_valid", int'({rsp1_valid, rsp0_valid}), 0);
        chk("rst_rsp", int'({rsp_cb, rsp_res}), 0);
        chk("rst_alu", int'({alu_cb_in, alu_mode, alu_b, alu_a}), 0);
        chk("rst_ready", int'({req1_ready, req0_ready}), 0);

        tbl[0]  = '{0, 9, 8, 0, 0, 1, 1};
        tbl[1]  = '{0, 2, 3, 0, 1, 6, 0};
        tbl[2]  = '{1, 2, 3, 0, 1, 5, 0};
        tbl[3]  = '{1, 3, 5, 1, 1, 14, 1};
        tbl[4]  = '{1, 12, 10, 2, 0, 8, 0};
        tbl[5]  = '{1, 1, 1, 0, 1, 3, 0};
        tbl[6]  = '{0, 15, 0, 6, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 7, 0, 15, 0};
        tbl[8]  = '{0, 7, 7, 1, 0, 0, 0};
        tbl[9]  = '{0, 15, 15, 0, 1, 14, 1};
        tbl[10] = '{0, 15, 0, 0, 1, 0, 1};
        tbl[11] = '{0, 15, 15, 2, 1, 15, 0};
        tbl[12] = '{0, 0, 0, 0, 1, 1, 0};
        for (int i = 0; i < 13; i++) begin
            model(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].chain, r, c);
            do_op(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].chain, tbl[i].res, tbl[i].cb);
        end

        for (int i = 0; i < 60; i++) begin
            int p, a, b, m, ch;
            p  = $urandom_range(1);
            a  = $urandom_range(15);
            b  = $urandom_range(15);
            m  = ($urandom_range(1) == 1) ? 0 : $urandom_range(7);
            ch = $urandom_range(1);
            model(p, a, b, m, ch, r, c);
            do_op(p, a, b, m, ch, r, c);
        end

        // Contention right after reset: grants alternate 0,1,0,1 back to back.
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 1, 1, 0, 0);
        set_req(1, 1'b1, 2, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            cnt = 0;
            while (!(req0_ready || req1_ready) && cnt < 10) begin
                @(negedge clk); #1; cnt++;
            end
            exp_port = k % 2;
            chk("cont_wait", cnt, 0);
            chk("cont_grant", int'({req1_ready, req0_ready}), exp_port == 0 ? 1 : 2);
            @(posedge clk);
            @(negedge clk);
            chk("cont_exec_no_rsp", int'({rsp1_valid, rsp0_valid}), 0);
            @(negedge clk);
            chk("cont_rsp_port", int'({rsp1_valid, rsp0_valid}), exp_port == 0 ? 1 : 2);
            chk("cont_rsp_res", int'(rsp_res), exp_port == 0 ? 2 : 3);
            chk("cont_ready_in_resp", int'({req1_ready, req0_ready}), 0);
            if (k == 3) begin
                set_req(0, 1'b0, 0, 0, 0, 0);
                set_req(1, 1'b0, 0, 0, 0, 0);
            end
        end

        // Reset during EXEC drops the operation and clears the carry flags.
        do_op(0, 9, 8, 0, 0, 1, 1);
        @(negedge clk);
        set_req(1, 1'b1, 7, 9, 0, 0);
        @(posedge clk); #1;
        set_req(1, 1'b0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_exec_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mcarry[0] = 0; mcarry[1] = 0;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_rsp", int'({rsp1_valid, rsp0_valid}), 0);
        chk("mid_rst_alu", int'({alu_cb_in, alu_mode, alu_b, alu_a}), 0);
        @(negedge clk);
        chk("mid_rst_no_pulse", int'({rsp1_valid, rsp0_valid}), 0);
        do_op(0, 0, 0, 0, 1, 0, 0);
        do_op(0, 15, 1, 0, 1, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
